// File: rtl/id_ex_fwd_stage.sv
// ---------------------------------------------------------------------------
// id_ex_fwd_stage
//
// ID/EX pipeline register followed by EX-stage operand forwarding. The stage
// captures the decoded instruction from ID, then presents ALU opcode and
// operands (with MEM/WB results forwarded in), forwarded store data and the
// resolved destination register to the EX stage.
//
// Optional feature (compile-time macro):
//   LOAD_USE_STALL_EN - when defined, a load in EX whose destination is read
//                       by the instruction in ID raises hazard_stall_o and
//                       inserts one bubble on the next edge. When undefined,
//                       hazard_stall_o is tied low and no internal bubbles are
//                       generated (load delay is handled by the toolchain).
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   stall_i, flush_i        hold stage / replace captured instruction by bubble
//   id_*                    decoded instruction fields from the ID stage
//   mem_reg_write/rd/result MEM-stage forwarding source (higher priority)
//   wb_reg_write/rd/data    WB-stage forwarding source
//   ex_alu_op/in_a/in_b     ALU controls and operands
//   ex_store_data           forwarded rt value for stores
//   ex_dest                 resolved destination register
//   ex_valid, ex_*          registered valid and control bits
//   hazard_stall_o          load-use hold request to IF/ID
// ---------------------------------------------------------------------------
module id_ex_fwd_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              id_valid,
  input  logic [2:0]        id_alu_op,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rs_val,
  input  logic [DATA_W-1:0] id_rt_val,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [2:0]        ex_alu_op,
  output logic [DATA_W-1:0] ex_in_a,
  output logic [DATA_W-1:0] ex_in_b,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_dest,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              hazard_stall_o
);

  // Operand slots handled by the forwarding network: 0 = rs, 1 = rt.
  localparam int NUM_OPS = 2;

  // -------------------------------------------------------------------------
  // Pipeline registers
  // -------------------------------------------------------------------------
  logic              valid_reg,      valid_next;
  logic [2:0]        alu_op_reg,     alu_op_next;
  logic              alu_src_reg,    alu_src_next;
  logic              reg_write_reg,  reg_write_next;
  logic              mem_read_reg,   mem_read_next;
  logic              mem_write_reg,  mem_write_next;
  logic              mem_to_reg_reg, mem_to_reg_next;
  logic [REG_AW-1:0] rs_reg,         rs_next;
  logic [REG_AW-1:0] rt_reg,         rt_next;
  logic [REG_AW-1:0] dest_reg,       dest_next;
  logic [DATA_W-1:0] rs_val_reg,     rs_val_next;
  logic [DATA_W-1:0] rt_val_reg,     rt_val_next;
  logic [DATA_W-1:0] imm_reg,        imm_next;

  // -------------------------------------------------------------------------
  // Forwarding network (combinational on the registered indices)
  // -------------------------------------------------------------------------
  logic [REG_AW-1:0] src_idx [NUM_OPS];
  logic [DATA_W-1:0] src_val [NUM_OPS];
  logic [DATA_W-1:0] fwd_val [NUM_OPS];

  assign src_idx[0] = rs_reg;
  assign src_idx[1] = rt_reg;
  assign src_val[0] = rs_val_reg;
  assign src_val[1] = rt_val_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OPS; gi++) begin : g_fwd
      logic mem_hit;
      logic wb_hit;
      // Register 0 is hardwired zero, so a write targeting it never forwards.
      assign mem_hit = mem_reg_write && (mem_rd != '0) && (mem_rd == src_idx[gi]);
      assign wb_hit  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == src_idx[gi]);
      // The MEM result is younger than the WB value and must win.
      assign fwd_val[gi] = mem_hit ? mem_result :
                           wb_hit  ? wb_data    :
                                     src_val[gi];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Load-use hazard detection
  // -------------------------------------------------------------------------
  logic hazard_int;

`ifdef LOAD_USE_STALL_EN
  // A load in EX cannot forward its data in time for the instruction in ID.
  // Once the bubble is inserted, ex_valid drops and the request clears itself.
  assign hazard_int = valid_reg && mem_read_reg && (dest_reg != '0) && id_valid &&
                      ((dest_reg == id_rs) || (dest_reg == id_rt));
`else
  assign hazard_int = 1'b0;
`endif

  assign hazard_stall_o = hazard_int;

  // Flush and the internal load-use bubble both zero the stage; either one
  // overrides a concurrent stall.
  logic bubble_req;
  assign bubble_req = flush_i || hazard_int;

  // -------------------------------------------------------------------------
  // Next-state selection: bubble > stall > capture
  // -------------------------------------------------------------------------
  always_comb begin
    // Default is the stall behaviour: hold the captured instruction, but keep
    // refreshing the operand values through the forwarding network so that a
    // producer that retires while we are stalled is still picked up.
    valid_next      = valid_reg;
    alu_op_next     = alu_op_reg;
    alu_src_next    = alu_src_reg;
    reg_write_next  = reg_write_reg;
    mem_read_next   = mem_read_reg;
    mem_write_next  = mem_write_reg;
    mem_to_reg_next = mem_to_reg_reg;
    rs_next         = rs_reg;
    rt_next         = rt_reg;
    dest_next       = dest_reg;
    rs_val_next     = fwd_val[0];
    rt_val_next     = fwd_val[1];
    imm_next        = imm_reg;

    if (bubble_req) begin
      valid_next      = 1'b0;
      alu_op_next     = 3'b000;
      alu_src_next    = 1'b0;
      reg_write_next  = 1'b0;
      mem_read_next   = 1'b0;
      mem_write_next  = 1'b0;
      mem_to_reg_next = 1'b0;
      rs_next         = '0;
      rt_next         = '0;
      dest_next       = '0;
      rs_val_next     = '0;
      rt_val_next     = '0;
      imm_next        = '0;
    end else if (!stall_i) begin
      valid_next      = id_valid;
      alu_op_next     = id_alu_op;
      alu_src_next    = id_alu_src;
      reg_write_next  = id_reg_write;
      mem_read_next   = id_mem_read;
      mem_write_next  = id_mem_write;
      mem_to_reg_next = id_mem_to_reg;
      rs_next         = id_rs;
      rt_next         = id_rt;
      dest_next       = id_reg_dst ? id_rd : id_rt;
      rs_val_next     = id_rs_val;
      rt_val_next     = id_rt_val;
      imm_next        = id_imm;
    end
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg      <= 1'b0;
      alu_op_reg     <= 3'b000;
      alu_src_reg    <= 1'b0;
      reg_write_reg  <= 1'b0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      mem_to_reg_reg <= 1'b0;
      rs_reg         <= '0;
      rt_reg         <= '0;
      dest_reg       <= '0;
      rs_val_reg     <= '0;
      rt_val_reg     <= '0;
      imm_reg        <= '0;
    end else begin
      valid_reg      <= valid_next;
      alu_op_reg     <= alu_op_next;
      alu_src_reg    <= alu_src_next;
      reg_write_reg  <= reg_write_next;
      mem_read_reg   <= mem_read_next;
      mem_write_reg  <= mem_write_next;
      mem_to_reg_reg <= mem_to_reg_next;
      rs_reg         <= rs_next;
      rt_reg         <= rt_next;
      dest_reg       <= dest_next;
      rs_val_reg     <= rs_val_next;
      rt_val_reg     <= rt_val_next;
      imm_reg        <= imm_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // With the registers cleared, index 0 blocks forwarding, so every output is
  // zero during reset without needing a clock edge.
  assign ex_alu_op     = alu_op_reg;
  assign ex_in_a       = fwd_val[0];
  assign ex_in_b       = alu_src_reg ? imm_reg : fwd_val[1];
  assign ex_store_data = fwd_val[1];
  assign ex_dest       = dest_reg;
  assign ex_valid      = valid_reg;
  assign ex_reg_write  = reg_write_reg;
  assign ex_mem_read   = mem_read_reg;
  assign ex_mem_write  = mem_write_reg;
  assign ex_mem_to_reg = mem_to_reg_reg;

endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_fwd_stage
//
// Directed bench for id_ex_fwd_stage: reset, capture, forwarding priority,
// zero register, immediate/store muxing, stall re-latch, flush, asynchronous
// reset mid-run and the load-use hazard (LOAD_USE_STALL_EN) or its absence.
// ---------------------------------------------------------------------------
module tb_id_ex_fwd_stage;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              stall_i, flush_i;
  logic              id_valid;
  logic [2:0]        id_alu_op;
  logic              id_alu_src, id_reg_dst;
  logic              id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic [DATA_W-1:0] id_rs_val, id_rt_val, id_imm;
  logic              mem_reg_write;
  logic [REG_AW-1:0] mem_rd;
  logic [DATA_W-1:0] mem_result;
  logic              wb_reg_write;
  logic [REG_AW-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic [2:0]        ex_alu_op;
  logic [DATA_W-1:0] ex_in_a, ex_in_b, ex_store_data;
  logic [REG_AW-1:0] ex_dest;
  logic              ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic              hazard_stall_o;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  id_ex_fwd_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .id_valid(id_valid), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
    .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_alu_op(ex_alu_op), .ex_in_a(ex_in_a), .ex_in_b(ex_in_b),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .hazard_stall_o(hazard_stall_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s: 0x%08h", tag, obs);
    end
  endtask

  // Present one valid instruction on the ID inputs.
  task automatic set_id(input logic [2:0] op, input logic src, input logic rdst,
                        input logic rw, input logic mr, input logic mw, input logic m2r,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] rsv, input logic [31:0] rtv,
                        input logic [31:0] imm);
    id_valid = 1'b1; id_alu_op = op; id_alu_src = src; id_reg_dst = rdst;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r;
    id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_val = rsv; id_rt_val = rtv; id_imm = imm;
  endtask

  task automatic clear_fwd();
    mem_reg_write = 1'b0; mem_rd = '0; mem_result = '0;
    wb_reg_write  = 1'b0; wb_rd  = '0; wb_data    = '0;
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    set_id(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    id_valid = 1'b0;
    clear_fwd();
    #12;
    check("reset ex_valid", {31'd0, ex_valid}, 32'd0);
    check("reset ex_in_a", ex_in_a, 32'd0);
    check("reset ex_dest", {27'd0, ex_dest}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain capture, rd destination, no forwarding.
    set_id(3'b010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 5'd4, 5'd6,
           32'h11, 32'h22, 32'h0);
    tick();
    check("cap ex_valid", {31'd0, ex_valid}, 32'd1);
    check("cap ex_alu_op", {29'd0, ex_alu_op}, 32'd2);
    check("cap ex_in_a", ex_in_a, 32'h11);
    check("cap ex_in_b", ex_in_b, 32'h22);
    check("cap ex_dest rd", {27'd0, ex_dest}, 32'd6);
    check("cap ex_reg_write", {31'd0, ex_reg_write}, 32'd1);

    // MEM beats WB; rt destination.
    set_id(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 5'd2, 5'd9,
           32'h1, 32'h33, 32'h0);
    tick();
    check("rt dest", {27'd0, ex_dest}, 32'd2);
    mem_reg_write = 1'b1; mem_rd = 5'd5; mem_result = 32'h10;
    wb_reg_write  = 1'b1; wb_rd  = 5'd5; wb_data    = 32'h20;
    #1 check("mem priority", ex_in_a, 32'h10);
    mem_reg_write = 1'b0;
    #1 check("wb after mem drop", ex_in_a, 32'h20);
    wb_reg_write = 1'b0;
    #1 check("no fwd rs_val", ex_in_a, 32'h1);
    clear_fwd();

    // Zero register never forwarded.
    set_id(3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0,
           32'h0, 32'h0, 32'h0);
    tick();
    mem_reg_write = 1'b1; mem_rd = 5'd0; mem_result = 32'hFF;
    wb_reg_write  = 1'b1; wb_rd  = 5'd0; wb_data    = 32'hEE;
    #1 check("zero reg in_a", ex_in_a, 32'h0);
    check("zero reg store", ex_store_data, 32'h0);
    clear_fwd();

    // Immediate on B, forwarded rt on store data.
    set_id(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 5'd9, 5'd0,
           32'h5, 32'h3, 32'hFFFF_FFFC);
    tick();
    wb_reg_write = 1'b1; wb_rd = 5'd9; wb_data = 32'h7;
    #1 check("imm in_b", ex_in_b, 32'hFFFF_FFFC);
    check("store fwd wb", ex_store_data, 32'h7);
    check("store mem_write", {31'd0, ex_mem_write}, 32'd1);
    clear_fwd();

    // Stall three cycles; WB writes rt in the second one.
    set_id(3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd13, 5'd12, 5'd14,
           32'h44, 32'h5, 32'h0);
    tick();
    stall_i = 1'b1;
    set_id(3'b100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd1, 5'd1,
           32'hAA, 32'hAA, 32'h0);
    tick();
    wb_reg_write = 1'b1; wb_rd = 5'd12; wb_data = 32'h9;
    tick();
    clear_fwd();
    tick();
    stall_i = 1'b0;
    #1 check("stall store relatch", ex_store_data, 32'h9);
    check("stall hold in_a", ex_in_a, 32'h44);
    check("stall hold dest", {27'd0, ex_dest}, 32'd14);
    check("stall hold valid", {31'd0, ex_valid}, 32'd1);
    stall_i = 1'b1; flush_i = 1'b1;
    tick();
    stall_i = 1'b0; flush_i = 1'b0;
    check("flush ex_valid", {31'd0, ex_valid}, 32'd0);
    check("flush ex_alu_op", {29'd0, ex_alu_op}, 32'd0);
    check("flush ex_reg_write", {31'd0, ex_reg_write}, 32'd0);
    check("flush ex_in_a", ex_in_a, 32'd0);

    // Asynchronous reset between edges.
    set_id(3'b011, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd7, 5'd8, 5'd9,
           32'h123, 32'h456, 32'h789);
    tick();
    check("pre-rst ex_valid", {31'd0, ex_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check("async rst ex_valid", {31'd0, ex_valid}, 32'd0);
    check("async rst ex_in_b", ex_in_b, 32'd0);
    check("async rst ex_mem_read", {31'd0, ex_mem_read}, 32'd0);
    check("async rst ex_alu_op", {29'd0, ex_alu_op}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load in EX (dest rt=8), consumer in ID reads rs=8.
    set_id(3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd2, 5'd8, 5'd0,
           32'h100, 32'h0, 32'h4);
    tick();
    check("lw in EX mem_read", {31'd0, ex_mem_read}, 32'd1);
    set_id(3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 5'd3, 5'd10,
           32'h0, 32'h6, 32'h0);
    #1;
`ifdef LOAD_USE_STALL_EN
    check("hazard raised", {31'd0, hazard_stall_o}, 32'd1);
    tick();
    check("hazard bubble", {31'd0, ex_valid}, 32'd0);
    check("hazard cleared", {31'd0, hazard_stall_o}, 32'd0);
    tick();
    mem_reg_write = 1'b1; mem_rd = 5'd8; mem_result = 32'h77;
    #1 check("consumer valid", {31'd0, ex_valid}, 32'd1);
    check("consumer mem fwd", ex_in_a, 32'h77);
`else
    check("hazard off", {31'd0, hazard_stall_o}, 32'd0);
    tick();
    check("no bubble consumer", {31'd0, ex_valid}, 32'd1);
    check("no bubble dest", {27'd0, ex_dest}, 32'd10);
`endif
    clear_fwd();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
